// File: rtl/nibble_serial_logic.sv
// ---------------------------------------------------------------------------
// nibble_serial_logic
//
// Sequential 32-bit bitwise logic unit. Computes AND / OR / XOR / NOR of two
// 32-bit operands one 4-bit nibble per clock, LSB nibble first, and presents
// the full result only at completion. This is the low-area counterpart of the
// combinational 32-bit logic slices in the datapath.
//
// Ports
//   clk     in   1   rising-edge clock
//   rst_n   in   1   asynchronous active-low reset
//   start   in   1   request; only sampled in IDLE or DONE
//   op      in   2   00 AND, 01 OR, 10 XOR, 11 NOR (latched with start)
//   input1  in  32   operand A (latched with start)
//   input2  in  32   operand B (latched with start)
//   busy    out  1   high while nibbles are being computed
//   done    out  1   one-cycle pulse; Output is valid from this cycle
//   Output  out 32   result register; holds until the next completion
//   zero    out  1   (Output == 0); present only with ZERO_FLAG_EN
//
// Build option
//   ZERO_FLAG_EN : when defined, adds the zero flag port and its logic.
//
// Timing: start sampled at edge E -> busy after E..E+8, nibble k computed at
// edge E+1+k, Output loaded at E+8, done high for the cycle after E+8. A new
// start in the DONE cycle is accepted without an IDLE gap.
// ---------------------------------------------------------------------------
module nibble_serial_logic (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] input1,
    input  logic [31:0] input2,
    output logic        busy,
    output logic        done,
    output logic [31:0] Output
`ifdef ZERO_FLAG_EN
    ,
    output logic        zero
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    state_t      r_state;
    state_t      w_next_state;

    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [1:0]  r_op;
    logic [2:0]  r_cnt;
    logic [31:0] r_shift;

    logic        w_accept;
    logic        w_last;
    logic [4:0]  w_bit_idx;
    logic [3:0]  w_a_nib;
    logic [3:0]  w_b_nib;
    logic [3:0]  w_nib;
    logic [31:0] w_shifted;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                // Back-to-back: a request in the DONE cycle goes straight to RUN.
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = S_RUN;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Nibble datapath
    // ------------------------------------------------------------------
    assign w_last    = (r_state == S_RUN) && (r_cnt == 3'd7);
    assign w_bit_idx = {r_cnt, 2'b00};
    assign w_a_nib   = r_a[w_bit_idx +: 4];
    assign w_b_nib   = r_b[w_bit_idx +: 4];

    always_comb begin
        w_nib = 4'h0;
        case (r_op)
            OP_AND:  w_nib = w_a_nib & w_b_nib;
            OP_OR:   w_nib = w_a_nib | w_b_nib;
            OP_XOR:  w_nib = w_a_nib ^ w_b_nib;
            OP_NOR:  w_nib = ~(w_a_nib | w_b_nib);
            default: w_nib = 4'h0;
        endcase
    end

    // New nibble enters at the top; after 8 shifts nibble k sits at [4k+3:4k].
    assign w_shifted = {w_nib, r_shift[31:4]};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Operand, counter, shift and result registers plus registered flags
    // ------------------------------------------------------------------
    // NOTE: all registers here are plain flops (no memory arrays), so every
    // one is cleared by reset; a mid-operation reset must leave nothing stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= 32'h0;
            r_b     <= 32'h0;
            r_op    <= 2'b00;
            r_cnt   <= 3'd0;
            r_shift <= 32'h0;
            Output  <= 32'h0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            busy <= (w_next_state == S_RUN);
            done <= (w_next_state == S_DONE);

            if (w_accept) begin
                r_a     <= input1;
                r_b     <= input2;
                r_op    <= op;
                r_cnt   <= 3'd0;
                r_shift <= 32'h0;
            end else if (r_state == S_RUN) begin
                r_shift <= w_shifted;
                r_cnt   <= r_cnt + 3'd1;
                // Output changes only at the completion edge, never partially.
                if (w_last) begin
                    Output <= w_shifted;
                end
            end
        end
    end

`ifdef ZERO_FLAG_EN
    assign zero = (Output == 32'h0);
`endif

endmodule

// File: tb/tb_nibble_serial_logic.sv
// ---------------------------------------------------------------------------
// tb_nibble_serial_logic
//
// Directed self-checking bench for nibble_serial_logic. Inputs change 1 ns
// after the rising edge; outputs are sampled at the same point, away from
// the active edge. Zero-flag checks are compiled in with ZERO_FLAG_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_nibble_serial_logic;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] input1;
    logic [31:0] input2;
    logic        busy;
    logic        done;
    logic [31:0] Output;
`ifdef ZERO_FLAG_EN
    logic        zero;
`endif

    int n_vec;
    int n_err;

    nibble_serial_logic dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .input1 (input1),
        .input2 (input2),
        .busy   (busy),
        .done   (done),
        .Output (Output)
`ifdef ZERO_FLAG_EN
        ,
        .zero   (zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pulse start for one accepting edge; returns just after that edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op     = o;
        input1 = a;
        input2 = b;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    // Count edges until done, bounded so a stuck DUT still reaches the summary.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int n_done;

        n_vec  = 0;
        n_err  = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        op     = 2'b00;
        input1 = 32'h0;
        input2 = 32'h0;

        // ---------------- Reset state ----------------
        tick();
        tick();
        check("rst_busy",   {31'h0, busy}, 32'h0);
        check("rst_done",   {31'h0, done}, 32'h0);
        check("rst_output", Output,        32'h0);
`ifdef ZERO_FLAG_EN
        check("rst_zero",   {31'h0, zero}, 32'h1);
`endif
        rst_n = 1'b1;
        tick();

        // ---------------- AND, cycle-accurate ----------------
        issue(2'b00, 32'hF0F0_1234, 32'hFF00_FFFF);        // now just after E
        check("and_busy_e1", {31'h0, busy}, 32'h1);
        for (int k = 1; k <= 7; k++) begin
            tick();                                        // edges E+1..E+7
            check("and_busy_run", {31'h0, busy}, 32'h1);
            check("and_nodone_run", {31'h0, done}, 32'h0);
            check("and_out_hold", Output, 32'h0);
        end
        tick();                                            // edge E+8
        check("and_done",    {31'h0, done}, 32'h1);
        check("and_busy_lo", {31'h0, busy}, 32'h0);
        check("and_result",  Output, 32'hF000_1234);
        tick();                                            // done must be a single cycle
        check("and_done_pulse", {31'h0, done}, 32'h0);
        check("and_out_keep",   Output, 32'hF000_1234);

        // ---------------- NOR ----------------
        issue(2'b11, 32'h0000_0000, 32'h0000_00FF);
        wait_done(lat);
        check("nor_latency", lat, 32'd8);
        check("nor_result",  Output, 32'hFFFF_FF00);
`ifdef ZERO_FLAG_EN
        check("nor_zero", {31'h0, zero}, 32'h0);
`endif
        tick();

        // ---------------- AND to zero ----------------
        issue(2'b00, 32'hAAAA_AAAA, 32'h5555_5555);
        wait_done(lat);
        check("and0_latency", lat, 32'd8);
        check("and0_result",  Output, 32'h0);
`ifdef ZERO_FLAG_EN
        check("and0_zero", {31'h0, zero}, 32'h1);
`endif
        tick();

        // ---------------- XOR then back-to-back OR ----------------
        issue(2'b10, 32'h1234_5678, 32'hFFFF_FFFF);
        wait_done(lat);
        check("xor_latency", lat, 32'd8);
        check("xor_result",  Output, 32'hEDCB_A987);
        // Still in the DONE cycle: request again with no IDLE gap.
        issue(2'b01, 32'h0F00_0000, 32'h0000_00F0);
        check("b2b_busy",    {31'h0, busy}, 32'h1);
        check("b2b_out_old", Output, 32'hEDCB_A987);
        wait_done(lat);
        check("b2b_latency", lat, 32'd8);
        check("b2b_result",  Output, 32'h0F00_00F0);
        tick();

        // ---------------- start and inputs churn during RUN ----------------
        issue(2'b00, 32'hFFFF_0000, 32'h0F0F_0F0F);
        n_done = 0;
        for (int k = 0; k < 8; k++) begin
            start  = 1'b1;
            op     = 2'(k);
            input1 = 32'h1357_9BDF ^ {4{8'(k)}};
            input2 = ~input1;
            tick();                                        // edges E+1..E+8
            if (done) n_done++;
        end
        start = 1'b0;
        check("ign_result", Output, 32'h0F0F_0000);
        for (int k = 0; k < 4; k++) begin
            tick();
            if (done) n_done++;
        end
        check("ign_one_done", n_done, 32'd1);
        check("ign_idle",     {31'h0, busy}, 32'h0);

        // ---------------- reset mid-run ----------------
        issue(2'b01, 32'hDEAD_BEEF, 32'h0000_0000);
        for (int k = 0; k < 4; k++) tick();                // in RUN, cycle 4
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", {31'h0, busy}, 32'h0);
        check("rst_mid_out",  Output, 32'h0);
        n_done = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (done) n_done++;
        end
        check("rst_mid_nodone", n_done, 32'd0);
        rst_n = 1'b1;
        tick();
        issue(2'b01, 32'h0000_0001, 32'h0000_0002);
        wait_done(lat);
        check("post_rst_latency", lat, 32'd8);
        check("post_rst_result",  Output, 32'h0000_0003);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
